// File: rtl/result_tx_arb_pkg.sv
// rtl/result_tx_arb_pkg.sv - FSM states, shared ASCII tags and length clamp for result_tx_arbiter
package result_tx_arb_pkg;

  typedef enum logic [1:0] {
    stIDLE    = 2'd0,
    stLOAD    = 2'd1,
    stSEND    = 2'd2,
    stRELEASE = 2'd3
  } arb_state_t;

  // Header bytes the puzzle engines put in front of their result value.
  localparam logic [7:0] TAG_PASS = 8'h50;
  localparam logic [7:0] TAG_FAIL = 8'h46;

  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/result_tx_arbiter_rr_grant.sv
// rtl/result_tx_arbiter_rr_grant.sv - combinational round-robin picker, first request at or after ptr wins
module rr_grant #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any
);

  int idx;

  // Scan from the far end so the candidate closest to ptr is written last and wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_tx_arbiter.sv
// rtl/result_tx_arbiter.sv - round-robin framer sharing one SPI byte transmitter among result engines
// Optional trailing XOR checksum byte: RESULT_TX_ARB_CHECKSUM_EN
module result_tx_arbiter
  import result_tx_arb_pkg::*;
#(
  parameter int  REQ_COUNT  = 3,
  parameter int  DATA_BYTES = 3,
  localparam int LEN_W      = $clog2(DATA_BYTES + 1),
  localparam int DATA_W     = 8 * DATA_BYTES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [REQ_COUNT-1:0]          req_valid,
  input  logic [8*REQ_COUNT-1:0]        req_tag,
  input  logic [DATA_W*REQ_COUNT-1:0]   req_data,
  input  logic [LEN_W*REQ_COUNT-1:0]    req_len,
  output logic [REQ_COUNT-1:0]          req_ready,
  input  logic                          spi_ready,
  input  logic [REQ_COUNT-1:0]          ss_out,
  output logic [7:0]                    tx_byte,
  output logic                          tx_byte_valid,
  output logic [REQ_COUNT-1:0]          ss_in,
  output logic                          busy
);

  localparam int PTR_W = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
  localparam int CNT_W = $clog2(DATA_BYTES + 3);
`ifdef RESULT_TX_ARB_CHECKSUM_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 1;
`endif

  arb_state_t           state;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     gnt_idx;
  logic [REQ_COUNT-1:0] gnt_onehot;
  logic [PTR_W-1:0]     pick_idx;
  logic [REQ_COUNT-1:0] pick_onehot;
  logic                 pick_any;
  logic [DATA_W-1:0]    shift_q;
  logic [CNT_W-1:0]     byte_cnt;
  logic [LEN_W-1:0]     cap_len;
  logic [DATA_W-1:0]    cap_data;
  logic [7:0]           next_byte;
`ifdef RESULT_TX_ARB_CHECKSUM_EN
  logic [7:0]           csum;
`endif

  rr_grant #(.N(REQ_COUNT), .PTR_W(PTR_W)) u_rr_grant (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (pick_onehot),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  // Left-justify the value so byte len-1 sits at the top of the shift register.
  always_comb begin
    cap_len   = LEN_W'(clamp_len(int'(req_len[gnt_idx*LEN_W +: LEN_W]), DATA_BYTES));
    cap_data  = req_data[gnt_idx*DATA_W +: DATA_W] << (8 * (DATA_BYTES - int'(cap_len)));
    next_byte = shift_q[DATA_W-1 -: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= stIDLE;
      rr_ptr        <= '0;
      gnt_idx       <= '0;
      gnt_onehot    <= '0;
      shift_q       <= '0;
      byte_cnt      <= '0;
      tx_byte       <= '0;
      tx_byte_valid <= 1'b0;
      ss_in         <= '1;
      req_ready     <= '0;
      busy          <= 1'b0;
`ifdef RESULT_TX_ARB_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      req_ready <= '0;
      case (state)
        stIDLE: begin
          if (pick_any) begin
            gnt_idx    <= pick_idx;
            gnt_onehot <= pick_onehot;
            req_ready  <= pick_onehot;
            busy       <= 1'b1;
            state      <= stLOAD;
          end
        end
        stLOAD: begin
          tx_byte       <= req_tag[gnt_idx*8 +: 8];
          shift_q       <= cap_data;
          byte_cnt      <= CNT_W'(int'(cap_len) + EXTRA);
          tx_byte_valid <= 1'b1;
          ss_in         <= ~gnt_onehot;
          state         <= stSEND;
`ifdef RESULT_TX_ARB_CHECKSUM_EN
          csum          <= req_tag[gnt_idx*8 +: 8];
`endif
        end
        stSEND: begin
          if (spi_ready) begin
            if (byte_cnt == CNT_W'(1)) begin
              tx_byte       <= '0;
              tx_byte_valid <= 1'b0;
              ss_in         <= '1;
              state         <= stRELEASE;
            end else begin
              byte_cnt <= byte_cnt - 1'b1;
              shift_q  <= shift_q << 8;
`ifdef RESULT_TX_ARB_CHECKSUM_EN
              if (byte_cnt == CNT_W'(2)) begin
                tx_byte <= csum;
              end else begin
                tx_byte <= next_byte;
                csum    <= csum ^ next_byte;
              end
`else
              tx_byte  <= next_byte;
`endif
            end
          end
        end
        stRELEASE: begin
          // Pad-side slave selects must all be released before the bus is handed on.
          if (&ss_out) begin
            rr_ptr <= (int'(gnt_idx) == REQ_COUNT - 1) ? '0 : gnt_idx + 1'b1;
            busy   <= 1'b0;
            state  <= stIDLE;
          end
        end
        default: state <= stIDLE;
      endcase
    end
  end

endmodule
